// File: rtl/heptagon_pkg.sv
// heptagon_pkg: shared sizes, FSM encoding and entry type for the heptagon-area stages
package heptagon_pkg;
   localparam int N_POLY = 5;
   localparam int AREA_W = 19;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = $clog2(N_POLY);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SORT = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;
   localparam logic [1:0] S_ACK  = 2'd3;
   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [AREA_W-1:0] area;
   } entry_t;
endpackage

// File: rtl/area_cmp_swap.sv
// area_cmp_swap: orders two entries by area, ties broken by index
module area_cmp_swap
   import heptagon_pkg::*;
(
   input  entry_t a_i,
   input  entry_t b_i,
   output entry_t lo_o,
   output entry_t hi_o
);
   logic swap;
   assign swap = (a_i.area > b_i.area) || (a_i.area == b_i.area && a_i.idx > b_i.idx);
   assign lo_o = swap ? b_i : a_i;
   assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/heptagon_area_sorter.sv
// heptagon_area_sorter: captures a batch of {index, area} pairs, sorts ascending, streams them, then acks
module heptagon_area_sorter
   import heptagon_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     area_on,
   input  logic [N_POLY*AREA_W-1:0] area_in,
   input  logic [N_POLY*IDX_W-1:0]  index_in,
   output logic                     valid_on,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         out_index,
   output logic [AREA_W-1:0]        out_area,
   output logic                     out_last,
   output logic                     busy
);
   localparam int NCS = N_POLY / 2;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d, rank_q, rank_d;
   entry_t           regs_q [N_POLY];
   entry_t           regs_d [N_POLY];
   entry_t           srt    [N_POLY];
   entry_t           lo_w   [NCS];
   entry_t           hi_w   [NCS];
   entry_t           out_q, out_d;
   logic             ov_q, ov_d, last_q, last_d, ack_q, ack_d;
   // Each unit serves pair (2j,2j+1) on even phases and (2j+1,2j+2) on odd phases
   for (genvar j = 0; j < NCS; j++) begin : g_cs
      entry_t a, b;
      if (2*j+2 < N_POLY) begin : g_both
         assign a = phase_q[0] ? regs_q[2*j+1] : regs_q[2*j];
         assign b = phase_q[0] ? regs_q[2*j+2] : regs_q[2*j+1];
      end else begin : g_even
         assign a = regs_q[2*j];
         assign b = regs_q[2*j+1];
      end
      area_cmp_swap u_cs (.a_i(a), .b_i(b), .lo_o(lo_w[j]), .hi_o(hi_w[j]));
   end
   always_comb begin
      srt = regs_q;
      for (int j = 0; j < NCS; j++) begin
         if (!phase_q[0]) begin
            srt[2*j]   = lo_w[j];
            srt[2*j+1] = hi_w[j];
         end else if (2*j+2 < N_POLY) begin
            srt[2*j+1] = lo_w[j];
            srt[2*j+2] = hi_w[j];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rank_d  = rank_q;
      regs_d  = regs_q;
      out_d   = out_q;
      ov_d    = ov_q;
      last_d  = last_q;
      ack_d   = ack_q;
      if (state_q == S_IDLE) begin
         if (area_on) begin
            for (int k = 0; k < N_POLY; k++)
               regs_d[k] = entry_t'{idx: index_in[k*IDX_W +: IDX_W], area: area_in[k*AREA_W +: AREA_W]};
            phase_d = '0;
            state_d = S_SORT;
         end
      end else if (state_q == S_SORT) begin
         regs_d  = srt;
         phase_d = phase_q + 1'b1;
         if (phase_q == CNT_W'(N_POLY-1)) begin
            state_d = S_EMIT;
            rank_d  = '0;
            ov_d    = 1'b1;
            out_d   = srt[0];
            last_d  = (N_POLY == 1);
         end
      end else if (state_q == S_EMIT) begin
         if (ov_q && out_ready) begin
            if (last_q) begin
               ov_d    = 1'b0;
               last_d  = 1'b0;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end else begin
               rank_d = rank_q + 1'b1;
               out_d  = regs_q[rank_d];
               last_d = (rank_d == CNT_W'(N_POLY-1));
            end
         end
      end else if (!area_on) begin
         ack_d   = 1'b0;
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         rank_q  <= '0;
         for (int k = 0; k < N_POLY; k++) regs_q[k] <= '0;
         out_q   <= '0;
         ov_q    <= 1'b0;
         last_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rank_q  <= rank_d;
         regs_q  <= regs_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
      end
   end
   assign valid_on  = ack_q;
   assign out_valid = ov_q;
   assign out_last  = last_q;
   assign out_index = out_q.idx;
   assign out_area  = out_q.area;
   assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_heptagon_area_sorter.sv
// tb_heptagon_area_sorter: directed and random batches checked against a sorted-key reference model
module tb_heptagon_area_sorter;
   import heptagon_pkg::*;
   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     area_on = 1'b0;
   logic                     out_ready = 1'b0;
   logic [N_POLY*AREA_W-1:0] area_in = '0;
   logic [N_POLY*IDX_W-1:0]  index_in = '0;
   logic                     valid_on, out_valid, out_last, busy;
   logic [IDX_W-1:0]         out_index;
   logic [AREA_W-1:0]        out_area;
   int                       ncmp = 0;
   int                       nfail = 0;
   int                       area_v [N_POLY];
   int                       idx_v  [N_POLY];

   heptagon_area_sorter dut (
      .clk(clk), .reset(reset), .area_on(area_on), .area_in(area_in), .index_in(index_in),
      .valid_on(valid_on), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .out_area(out_area), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid_on"}, 32'(valid_on), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_last"}, 32'(out_last), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_out_index"}, 32'(out_index), 0);
      chk({tag, "_out_area"}, 32'(out_area), 0);
   endtask

   task automatic set_batch(input int a0, input int a1, input int a2, input int a3, input int a4);
      area_v = '{a0, a1, a2, a3, a4};
      for (int k = 0; k < N_POLY; k++) idx_v[k] = k + 1;
   endtask

   task automatic drive_batch();
      area_on = 1'b1;
      for (int k = 0; k < N_POLY; k++) begin
         area_in[k*AREA_W +: AREA_W] = AREA_W'(area_v[k]);
         index_in[k*IDX_W +: IDX_W]  = IDX_W'(idx_v[k]);
      end
   endtask

   // Model: a batch sorted ascending by the combined key area*2^IDX_W + index
   task automatic run_batch(input int stall, input int hold);
      int q[$];
      int beats = 0;
      int cyc = 0;
      for (int k = 0; k < N_POLY; k++) q.push_back(area_v[k] * (1 << IDX_W) + idx_v[k]);
      q.sort();
      drive_batch();
      step();
      chk("busy_after_capture", 32'(busy), 1);
      for (int k = 0; k < N_POLY; k++) begin
         area_in[k*AREA_W +: AREA_W] = AREA_W'($urandom);
         index_in[k*IDX_W +: IDX_W]  = IDX_W'($urandom);
      end
      for (int c = 0; c < N_POLY - 1; c++) begin
         chk("no_early_valid", 32'(out_valid), 0);
         step();
      end
      chk("no_early_valid", 32'(out_valid), 0);
      step();
      chk("latency", 32'(out_valid), 1);
      while (beats < N_POLY && cyc < 100) begin
         out_ready = (stall == 0) ? 1'b1 : (cyc % 3 == 0);
         chk("valid_held", 32'(out_valid), 1);
         chk("no_early_ack", 32'(valid_on), 0);
         chk("beat_index", 32'(out_index), 32'(q[beats] % (1 << IDX_W)));
         chk("beat_area", 32'(out_area), 32'(q[beats] / (1 << IDX_W)));
         chk("beat_last", 32'(out_last), 32'(beats == N_POLY - 1));
         if (out_valid && out_ready) beats++;
         cyc++;
         step();
      end
      out_ready = 1'b0;
      chk("beat_count", 32'(beats), N_POLY);
      chk("valid_drop", 32'(out_valid), 0);
      chk("ack_rise", 32'(valid_on), 1);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("ack_hold", 32'(valid_on), 1);
         chk("ack_busy", 32'(busy), 1);
      end
      area_on = 1'b0;
      step();
      chk("ack_release", 32'(valid_on), 0);
      chk("back_idle", 32'(busy), 0);
   endtask

   initial begin
      step();
      step();
      chk_zero("reset");
      reset = 1'b0;
      step();
      set_batch(300, 100, 500, 200, 400);
      run_batch(0, 0);
      step();
      chk("no_recapture", 32'(busy), 0);
      set_batch(7, 7, 7, 7, 7);
      run_batch(0, 0);
      set_batch(5, 4, 3, 2, 1);
      run_batch(1, 0);
      set_batch(9, 1, 8, 2, 7);
      run_batch(0, 4);
      step();
      chk("no_stale_capture", 32'(busy), 0);
      set_batch(11, 12, 13, 14, 15);
      drive_batch();
      step();
      step();
      step();
      reset = 1'b1;
      area_on = 1'b0;
      step();
      chk_zero("abort");
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("abort_no_ack", 32'(valid_on), 0);
      end
      set_batch(0, 524287, 1, 2, 3);
      run_batch(0, 1);
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < N_POLY; k++) begin
            idx_v[k]  = k + 1;
            area_v[k] = (b % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 524287));
         end
         for (int k = N_POLY - 1; k > 0; k--) begin
            int j = int'($urandom_range(0, k));
            int t = idx_v[k];
            idx_v[k] = idx_v[j];
            idx_v[j] = t;
         end
         run_batch(b % 2, b % 3);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
